pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_bit.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and the
// sizing helper for the single cycle counter.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        PLL_RESET = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Width able to hold (largest cycle count - 1); never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, with synchronous clear.
// Reused for any single-bit clock-domain crossing.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < 2) begin : gen_bad_stages
        $error("sync_bit: STAGES must be 2 or more");
    end

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the chain; clear flushes every stage.
    always_ff @(posedge clock) begin
        if (i_clr) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds downstream logic in reset until the board PLL lock has been stable for
// STABLE_CYCLES plus HOLD_CYCLES, drops back to waiting on any lock loss, and
// pulses the PLL reset and retries if lock never arrives within TIMEOUT_CYCLES.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             sys_ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] retry_count
);

    if (SYNC_STAGES < 2) begin : gen_bad_sync
        $error("pll_reset_sequencer: SYNC_STAGES must be 2 or more");
    end
    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1) begin : gen_bad_cycles
        $error("pll_reset_sequencer: all cycle parameters must be 1 or more");
    end
    if (CNT_W < 1) begin : gen_bad_cnt_w
        $error("pll_reset_sequencer: CNT_W must be 1 or more");
    end

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES);

    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);

    logic             w_locked_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             w_retry_hit;
    logic             w_loss_hit;
    logic             r_pll_rst;
    logic             r_sys_reset;
    logic             r_sys_ready;
    logic [CNT_W-1:0] r_lock_loss_count;
    logic [CNT_W-1:0] r_retry_count;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock (clock),
        .i_clr (reset),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    // Next-state decode; a lock drop always wins over the counter terminal test.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        w_state_nxt = r_state;
        w_retry_hit = 1'b0;
        w_loss_hit  = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = PLL_RESET;
                    w_retry_hit = 1'b1;
                end
            end
            PLL_RESET: begin
                if (r_cnt == PLL_RST_LAST) w_state_nxt = WAIT_LOCK;
            end
            STABLE: begin
                if (!w_locked_s)                w_state_nxt = WAIT_LOCK;
                else if (r_cnt == STABLE_LAST)  w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!w_locked_s)                w_state_nxt = WAIT_LOCK;
                else if (r_cnt == HOLD_LAST)    w_state_nxt = RUN;
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_loss_hit  = 1'b1;
                end
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    // State, cycle counter, output decodes and status counters advance together.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
        if (reset) begin
            r_state           <= WAIT_LOCK;
            r_cnt             <= '0;
            r_pll_rst         <= 1'b0;
            r_sys_reset       <= 1'b1;
            r_sys_ready       <= 1'b0;
            r_lock_loss_count <= '0;
            r_retry_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pll_rst   <= (w_state_nxt == PLL_RESET);
            r_sys_reset <= (w_state_nxt != RUN);
            r_sys_ready <= (w_state_nxt == RUN);

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_retry_hit && (r_retry_count != '1)) begin
                r_retry_count <= r_retry_count + 1'b1;
            end
            if (w_loss_hit && (r_lock_loss_count != '1)) begin
                r_lock_loss_count <= r_lock_loss_count + 1'b1;
            end
        end
    end

    assign pll_rst         = r_pll_rst;
    assign sys_reset       = r_sys_reset;
    assign sys_ready       = r_sys_ready;
    assign lock_loss_count = r_lock_loss_count;
    assign retry_count     = r_retry_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
// Edge numbering: the first clock edge that samples a new pll_locked value is
// edge 1; release lands on edge SYNC+1+STABLE+HOLD = 10, re-assert on edge 3.
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES    = 2;
    localparam int STABLE_CYCLES  = 4;
    localparam int HOLD_CYCLES    = 3;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int PLL_RST_CYCLES = 5;
    localparam int CNT_W          = 2;

    logic             clock;
    logic             reset;
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_reset;
    logic             sys_ready;
    logic [CNT_W-1:0] lock_loss_count;
    logic [CNT_W-1:0] retry_count;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_reset       (sys_reset),
        .sys_ready       (sys_ready),
        .lock_loss_count (lock_loss_count),
        .retry_count     (retry_count)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs are driven and outputs sampled 1 ns after.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Count edges until sys_reset falls; sys_ready must mirror it throughout.
    task automatic measure_release(input string tag, input int exp);
        int   n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        while (sys_reset === 1'b1 && n < 100) begin
            tick(1);
            n++;
            if (sys_ready === sys_reset) bad = 1'b1;
        end
        check({tag, "_edges"}, n, exp);
        check({tag, "_ready"}, sys_ready, 1);
        check({tag, "_excl"}, bad, 0);
    endtask

    // Count edges until sys_reset rises again.
    task automatic measure_assert(input string tag, input int exp);
        int n;
        n = 0;
        while (sys_reset === 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        check({tag, "_edges"}, n, exp);
        check({tag, "_ready"}, sys_ready, 0);
    endtask

    initial begin
        int   e;
        int   rises;
        int   rise_at[4];
        int   width[4];
        int   rc[4];
        logic prev;
        logic seen_ready;

        // Power-up: reset for 3 cycles with lock already present.
        reset      = 1'b1;
        pll_locked = 1'b1;
        tick(3);
        check("por_sys_reset", sys_reset, 1);
        check("por_sys_ready", sys_ready, 0);
        check("por_pll_rst", pll_rst, 0);
        check("por_loss", lock_loss_count, 0);
        check("por_retry", retry_count, 0);
        reset = 1'b0;
        measure_release("powerup", 10);
        check("powerup_loss", lock_loss_count, 0);
        check("powerup_retry", retry_count, 0);

        // Lock loss in RUN: reset re-asserts on edge 3 and is counted.
        pll_locked = 1'b0;
        measure_assert("runloss", 3);
        check("runloss_count", lock_loss_count, 1);

        // Re-lock, then glitch low for 2 cycles while in STABLE.
        pll_locked = 1'b1;
        tick(4);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        check("glitch_sys_reset", sys_reset, 1);
        measure_release("glitch", 10);
        check("glitch_loss", lock_loss_count, 1);

        // Timeout/retry: lock held low; pulses of 5 every 25, retry saturates at 3.
        pll_locked = 1'b0;
        e     = 0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rise_at[i] = 0;
            width[i]   = 0;
            rc[i]      = 0;
        end
        while ((rises < 4 || pll_rst === 1'b1) && e < 200) begin
            tick(1);
            e++;
            if (pll_rst === 1'b1 && !prev) begin
                rise_at[rises] = e;
                rc[rises]      = int'(retry_count);
                rises++;
            end else if (pll_rst !== 1'b1 && prev && rises > 0) begin
                width[rises-1] = e - rise_at[rises-1];
            end
            prev = (pll_rst === 1'b1);
        end
        check("retry_pulses", rises, 4);
        check("retry_first_rise", rise_at[0], 23);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("retry_period%0d", i), rise_at[i] - rise_at[i-1], 25);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("retry_width%0d", i), width[i], 5);
        end
        check("retry_count0", rc[0], 1);
        check("retry_count1", rc[1], 2);
        check("retry_count2", rc[2], 3);
        check("retry_count3", rc[3], 3);
        check("retry_loss", lock_loss_count, 2);
        check("retry_sys_reset", sys_reset, 1);

        // Reset in HOLD: lock, reach HOLD on edge 7, then reset.
        pll_locked = 1'b1;
        tick(7);
        check("hold_pre_sys_reset", sys_reset, 1);
        reset = 1'b1;
        tick(1);
        check("holdrst_sys_reset", sys_reset, 1);
        check("holdrst_sys_ready", sys_ready, 0);
        check("holdrst_pll_rst", pll_rst, 0);
        check("holdrst_loss", lock_loss_count, 0);
        check("holdrst_retry", retry_count, 0);
        reset = 1'b0;
        measure_release("holdrst", 10);

        // Lock drop arriving on the HOLD terminal cycle: must not reach RUN.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(7);
        pll_locked = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (sys_ready !== 1'b0) seen_ready = 1'b1;
        end
        check("holdterm_no_ready", seen_ready, 0);
        check("holdterm_sys_reset", sys_reset, 1);
        check("holdterm_loss", lock_loss_count, 0);
        pll_locked = 1'b1;
        measure_release("holdterm", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
